// File: rtl/alarm_annunciator.sv
// rtl/alarm_annunciator.sv - operator annunciator driven by the security FSM status outputs
//
// Purpose:
//   Turns the security FSM state and alarm bit into operator-facing signals:
//   a pre-warning strobe, a patterned siren, an escalation flag for an alarm
//   nobody responds to, and an acknowledge handshake that silences the siren.
//
// Parameters:
//   ON_CYC    siren-high cycles per pattern period (>=1)
//   OFF_CYC   siren-low cycles per pattern period (>=1)
//   ESC_CYC   unacknowledged SOUND cycles before escalation (>=1)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   sec_state  in   security FSM state (00 OFF, 01 ARMED, 10 TRIGGERED, 11 ALARM_ON)
//   sec_next   in   security FSM next state (not used)
//   sec_alarm  in   security FSM alarm bit
//   ack        in   operator acknowledge, level-sampled
//   ack_req    out  acknowledge requested
//   siren      out  siren drive
//   strobe     out  pre-warning / visual indicator
//   escalate   out  unacknowledged-timeout flag
//   evt_count  out  saturating alarm event count
//   ann_state  out  internal state (00 IDLE, 01 PREWARN, 10 SOUND, 11 SILENCED)

module alarm_annunciator #(
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 4,
    parameter int ESC_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sec_state,
    input  logic [1:0] sec_next,
    input  logic       sec_alarm,
    input  logic       ack,
    output logic       ack_req,
    output logic       siren,
    output logic       strobe,
    output logic       escalate,
    output logic [7:0] evt_count,
    output logic [1:0] ann_state
);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_PREWARN  = 2'b01;
    localparam logic [1:0] ST_SOUND    = 2'b10;
    localparam logic [1:0] ST_SILENCED = 2'b11;

    localparam int PW = (ON_CYC + OFF_CYC > 2) ? $clog2(ON_CYC + OFF_CYC) : 1;
    localparam int EW = (ESC_CYC > 1) ? $clog2(ESC_CYC + 1) : 1;

    localparam logic [PW-1:0] PH_ON  = PW'(ON_CYC);
    localparam logic [PW-1:0] PH_MAX = PW'(ON_CYC + OFF_CYC - 1);
    localparam logic [EW-1:0] ESC_LIM = EW'(ESC_CYC);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [EW-1:0] esc_q, esc_d;
    logic [7:0]    evt_q, evt_d;
    logic          siren_q, siren_d;
    logic          strobe_q, strobe_d;
    logic          escalate_q, escalate_d;
    logic          ack_req_q, ack_req_d;

    // sec_next is carried on the bus for compatibility only.
    logic unused_sec_next;
    assign unused_sec_next = ^sec_next;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sec_alarm)
                    state_d = ST_SOUND;
                else if (sec_state == 2'b10)
                    state_d = ST_PREWARN;
            end
            ST_PREWARN: begin
                if (sec_alarm)
                    state_d = ST_SOUND;
                else if (!sec_state[1])
                    state_d = ST_IDLE;
            end
            ST_SOUND: begin
                // Alarm dropping wins over a same-cycle ack: the ack is
                // consumed and SILENCED is skipped.
                if (!sec_alarm)
                    state_d = ST_IDLE;
                else if (ack && ack_req_q)
                    state_d = ST_SILENCED;
            end
            default: begin
                // SILENCED holds until the alarm falls, so a level held high
                // across it can never be re-counted as a new event.
                if (!sec_alarm)
                    state_d = ST_IDLE;
            end
        endcase
    end

    // Counters and registered outputs, all derived from the next state so
    // every response is visible right after the sampling edge.
    always_comb begin
        phase_d = '0;
        esc_d   = '0;
        evt_d   = evt_q;
        if (state_d == ST_SOUND) begin
            if (state_q != ST_SOUND) begin
                if (evt_q != 8'hFF)
                    evt_d = evt_q + 8'd1;
            end else begin
                phase_d = (phase_q == PH_MAX) ? '0 : phase_q + 1'b1;
                esc_d   = (esc_q == ESC_LIM) ? esc_q : esc_q + 1'b1;
            end
        end

        escalate_d = (state_d == ST_SOUND) && (esc_d == ESC_LIM);
        siren_d    = (state_d == ST_SOUND) && (escalate_d || (phase_d < PH_ON));
        ack_req_d  = (state_d == ST_SOUND);
        strobe_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            esc_q      <= '0;
            evt_q      <= 8'd0;
            siren_q    <= 1'b0;
            strobe_q   <= 1'b0;
            escalate_q <= 1'b0;
            ack_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            esc_q      <= esc_d;
            evt_q      <= evt_d;
            siren_q    <= siren_d;
            strobe_q   <= strobe_d;
            escalate_q <= escalate_d;
            ack_req_q  <= ack_req_d;
        end
    end

    assign ann_state = state_q;
    assign evt_count = evt_q;
    assign siren     = siren_q;
    assign strobe    = strobe_q;
    assign escalate  = escalate_q;
    assign ack_req   = ack_req_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb/tb_alarm_annunciator.sv - directed self-checking bench for alarm_annunciator

module tb_alarm_annunciator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sec_state = 2'b00;
    logic [1:0] sec_next = 2'b00;
    logic       sec_alarm = 1'b0;
    logic       ack = 1'b0;
    logic       ack_req;
    logic       siren;
    logic       strobe;
    logic       escalate;
    logic [7:0] evt_count;
    logic [1:0] ann_state;

    int checks = 0;
    int errors = 0;
    int sound_k = 0;

    alarm_annunciator #(.ON_CYC(4), .OFF_CYC(4), .ESC_CYC(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_state (sec_state),
        .sec_next  (sec_next),
        .sec_alarm (sec_alarm),
        .ack       (ack),
        .ack_req   (ack_req),
        .siren     (siren),
        .strobe    (strobe),
        .escalate  (escalate),
        .evt_count (evt_count),
        .ann_state (ann_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({ann_state, siren, strobe, escalate, ack_req} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", {ann_state, siren, strobe, escalate, ack_req}, 6'b0);
        end
        checks++;
        if (evt_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_evt: got %0d expected 0", evt_count);
        end
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_prewarn();
        sec_state = 2'b00; tick();
        sec_state = 2'b01; tick();
        checks++;
        if (ann_state !== 2'b00 || strobe !== 1'b0) begin
            errors++;
            $display("FAIL prewarn_armed: state %b strobe %b expected 00 0", ann_state, strobe);
        end
        sec_state = 2'b10; tick();
        checks++;
        if (ann_state !== 2'b01 || strobe !== 1'b1) begin
            errors++;
            $display("FAIL prewarn_enter: state %b strobe %b expected 01 1", ann_state, strobe);
        end
        checks++;
        if ({siren, escalate, ack_req} !== 3'b000 || evt_count !== 8'd0) begin
            errors++;
            $display("FAIL prewarn_quiet: siren/esc/ackreq %b evt %0d expected 000 0", {siren, escalate, ack_req}, evt_count);
        end
        sec_state = 2'b01; tick();
        checks++;
        if (ann_state !== 2'b00 || strobe !== 1'b0) begin
            errors++;
            $display("FAIL prewarn_exit: state %b strobe %b expected 00 0", ann_state, strobe);
        end
    endtask

    task automatic test_siren_pattern();
        sec_state = 2'b11;
        sec_alarm = 1'b1;
        tick();
        sound_k = 0;
        checks++;
        if (ann_state !== 2'b10 || ack_req !== 1'b1 || strobe !== 1'b1 || evt_count !== 8'd1) begin
            errors++;
            $display("FAIL sound_entry: state %b ackreq %b strobe %b evt %0d expected 10 1 1 1", ann_state, ack_req, strobe, evt_count);
        end
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            sound_k = k;
            checks++;
            if (siren !== ((k % 8) < 4)) begin
                errors++;
                $display("FAIL siren_pattern k=%0d: got %b expected %b", k, siren, (k % 8) < 4);
            end
        end
    endtask

    task automatic test_escalation();
        for (int k = sound_k + 1; k <= 68; k++) begin
            tick();
            checks++;
            if (siren !== ((k >= 64) || ((k % 8) < 4)) || escalate !== (k >= 64) || ack_req !== 1'b1) begin
                errors++;
                $display("FAIL escalation k=%0d: siren %b esc %b ackreq %b expected %b %b 1",
                         k, siren, escalate, ack_req, (k >= 64) || ((k % 8) < 4), k >= 64);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (ann_state !== 2'b11 || {siren, escalate, ack_req, strobe} !== 4'b0001) begin
            errors++;
            $display("FAIL ack_silence: state %b siren/esc/ackreq/strobe %b expected 11 0001", ann_state, {siren, escalate, ack_req, strobe});
        end
    endtask

    task automatic test_hold_silenced();
        repeat (20) tick();
        checks++;
        if (ann_state !== 2'b11 || evt_count !== 8'd1 || siren !== 1'b0) begin
            errors++;
            $display("FAIL hold_silenced: state %b evt %0d siren %b expected 11 1 0", ann_state, evt_count, siren);
        end
        sec_alarm = 1'b0;
        tick();
        checks++;
        if (ann_state !== 2'b00 || strobe !== 1'b0) begin
            errors++;
            $display("FAIL silenced_exit: state %b strobe %b expected 00 0", ann_state, strobe);
        end
    endtask

    task automatic test_stray_ack();
        ack = 1'b1;
        tick();
        checks++;
        if (ann_state !== 2'b00 || ack_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_idle: state %b ackreq %b expected 00 0", ann_state, ack_req);
        end
        ack = 1'b0;
        sec_alarm = 1'b1;
        tick();
        checks++;
        if (ann_state !== 2'b10 || ack_req !== 1'b1 || siren !== 1'b1 || evt_count !== 8'd2) begin
            errors++;
            $display("FAIL stray_ack_forgotten: state %b ackreq %b siren %b evt %0d expected 10 1 1 2", ann_state, ack_req, siren, evt_count);
        end
        ack = 1'b1;
        sec_alarm = 1'b0;
        tick();
        ack = 1'b0;
        checks++;
        if (ann_state !== 2'b00 || {siren, strobe, ack_req} !== 3'b000 || evt_count !== 8'd2) begin
            errors++;
            $display("FAIL ack_and_drop: state %b outs %b evt %0d expected 00 000 2", ann_state, {siren, strobe, ack_req}, evt_count);
        end
    endtask

    task automatic test_drop_no_ack();
        sec_alarm = 1'b1;
        tick();
        sec_alarm = 1'b0;
        tick();
        checks++;
        if (ann_state !== 2'b00 || {siren, strobe, escalate, ack_req} !== 4'b0000 || evt_count !== 8'd3) begin
            errors++;
            $display("FAIL drop_no_ack: state %b outs %b evt %0d expected 00 0000 3", ann_state, {siren, strobe, escalate, ack_req}, evt_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            sec_alarm = 1'b1;
            tick();
            sec_alarm = 1'b0;
            tick();
            if (i == 200) begin
                checks++;
                if (evt_count !== 8'd204) begin
                    errors++;
                    $display("FAIL evt_midway: got %0d expected 204", evt_count);
                end
            end
        end
        checks++;
        if (evt_count !== 8'd255 || ann_state !== 2'b00) begin
            errors++;
            $display("FAIL evt_saturate: evt %0d state %b expected 255 00", evt_count, ann_state);
        end
    endtask

    task automatic test_async_reset();
        sec_alarm = 1'b1;
        tick();
        tick();
        checks++;
        if (ann_state !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_sound: state %b expected 10", ann_state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ann_state, siren, strobe, escalate, ack_req} !== 6'b0 || evt_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: outs %b evt %0d expected 000000 0", {ann_state, siren, strobe, escalate, ack_req}, evt_count);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (ann_state !== 2'b10 || evt_count !== 8'd1 || siren !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_sound: state %b evt %0d siren %b expected 10 1 1", ann_state, evt_count, siren);
        end
    endtask

    initial begin
        test_reset();
        test_prewarn();
        test_siren_pattern();
        test_escalation();
        test_hold_silenced();
        test_stray_ack();
        test_drop_no_ack();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
